// File: rtl/mem_access_fsm_if.sv
// rtl/mem_access_fsm_if.sv - handshake/strobe bundle between the load/store sequencer and the datapath
// master = sequencer side, slave = datapath/memory side.
interface mem_access_fsm_if #(
  parameter int DATA_W = 16,
  parameter int NREG   = 6
);
  logic              IF_active;
  logic [DATA_W-1:0] instruction;
  logic              MFC;
  logic              busy;
  logic              done;
  logic              err;
  logic [1:0]        err_code;
  logic              memEN;
  logic              RW;
  logic              marIn;
  logic              mdrWriteEN;
  logic              mdrReadEN;
  logic              mdrOut;
  logic              pcInc;
  logic [NREG-1:0]   rxOut;
  logic [NREG-1:0]   rxIn;

  modport master (
    input  IF_active, instruction, MFC,
    output busy, done, err, err_code, memEN, RW, marIn,
           mdrWriteEN, mdrReadEN, mdrOut, pcInc, rxOut, rxIn
  );

  modport slave (
    output IF_active, instruction, MFC,
    input  busy, done, err, err_code, memEN, RW, marIn,
           mdrWriteEN, mdrReadEN, mdrOut, pcInc, rxOut, rxIn
  );
endinterface

// File: rtl/mem_access_fsm.sv
// rtl/mem_access_fsm.sv - parametrised LOAD/STORE sequencer driving MAR/MDR/register/memory strobes
// Strobes are flopped from the decoded state, so they trail the state register by one cycle.
module mem_access_fsm #(
  parameter int         DATA_W      = 16,
  parameter int         NREG        = 6,
  parameter logic [3:0] OPC_LOAD    = 4'b0011,
  parameter logic [3:0] OPC_STORE   = 4'b0100,
  parameter int         MFC_TIMEOUT = 15
) (
  input logic              clk,
  input logic              rst,
  mem_access_fsm_if.master bus
);
  localparam int PW = (DATA_W - 4) / 2;
  localparam int CW = $clog2(MFC_TIMEOUT + 1);

  typedef enum logic [3:0] {
    S_IDLE, S_ADDR, S_MAR, S_SDATA, S_SMDR, S_WAIT, S_LOUT, S_DONE, S_ERR
  } state_t;

  state_t            state, nxt;
  logic [DATA_W-1:0] instr_q;
  logic [CW-1:0]     cnt;
  logic [1:0]        err_code_q;
  logic              start, code_set;
  logic [1:0]        code_nxt;

  logic [3:0]    in_op;
  logic [PW-1:0] in_p1, in_p2, q_p1, q_p2;
  logic          is_store;

  logic d_busy, d_done, d_err, d_mem, d_rw, d_mar, d_mdw, d_mdr, d_mout, d_pc;
  logic [NREG-1:0] d_rxo, d_rxi;

  assign in_op    = bus.instruction[DATA_W-1 -: 4];
  assign in_p1    = bus.instruction[DATA_W-5 -: PW];
  assign in_p2    = bus.instruction[PW-1:0];
  assign q_p1     = instr_q[DATA_W-5 -: PW];
  assign q_p2     = instr_q[PW-1:0];
  assign is_store = (instr_q[DATA_W-1 -: 4] == OPC_STORE);
  assign bus.err_code = err_code_q;

  // Register 0 maps to the MSB of the select vector.
  function automatic logic [NREG-1:0] onehot(input logic [PW-1:0] idx);
    logic [NREG-1:0] oh;
    oh = '0;
    for (int i = 0; i < NREG; i++) oh[NREG-1-i] = (idx == PW'(i));
    return oh;
  endfunction

  function automatic logic bad_reg(input logic [PW-1:0] idx);
    return 32'(idx) >= 32'(NREG);
  endfunction

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state      <= S_IDLE;
      instr_q    <= '0;
      err_code_q <= 2'b00;
    end else begin
      state <= nxt;
      if (start) instr_q <= bus.instruction;
      if (start || code_set) err_code_q <= code_nxt;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst)                cnt <= '0;
    else if (state != S_WAIT) cnt <= '0;
    else if (!bus.MFC)      cnt <= cnt + CW'(1);
  end

  always_comb begin
    nxt      = state;
    start    = 1'b0;
    code_set = 1'b0;
    code_nxt = 2'b00;
    if (bus.IF_active) begin
      nxt = S_IDLE;
    end else begin
      case (state)
        S_IDLE: begin
          if (in_op == OPC_LOAD || in_op == OPC_STORE) begin
            start = 1'b1;
            if (bad_reg(in_p1) || bad_reg(in_p2)) begin
              nxt      = S_ERR;
              code_nxt = 2'b01;
            end else begin
              nxt = S_ADDR;
            end
          end
        end
        S_ADDR:  nxt = S_MAR;
        S_MAR:   nxt = is_store ? S_SDATA : S_WAIT;
        S_SDATA: nxt = S_SMDR;
        S_SMDR:  nxt = S_WAIT;
        S_WAIT: begin
          if (bus.MFC) begin
            nxt = is_store ? S_DONE : S_LOUT;
          end else if (cnt == CW'(MFC_TIMEOUT - 1)) begin
            nxt      = S_ERR;
            code_set = 1'b1;
            code_nxt = 2'b10;
          end
        end
        S_LOUT:  nxt = S_DONE;
        S_DONE:  nxt = S_IDLE;
        S_ERR:   nxt = S_IDLE;
        default: nxt = S_IDLE;
      endcase
    end
  end

  always_comb begin
    d_busy = (state != S_IDLE);
    d_done = 1'b0;
    d_err  = 1'b0;
    d_mem  = 1'b0;
    d_rw   = 1'b0;
    d_mar  = 1'b0;
    d_mdw  = 1'b0;
    d_mdr  = 1'b0;
    d_mout = 1'b0;
    d_pc   = 1'b0;
    d_rxo  = '0;
    d_rxi  = '0;
    case (state)
      S_ADDR:  begin d_rxo = onehot(q_p2); d_pc  = 1'b1; end
      S_MAR:   begin d_rxo = onehot(q_p2); d_mar = 1'b1; end
      S_SDATA: d_rxo = onehot(q_p1);
      S_SMDR:  begin d_rxo = onehot(q_p1); d_mdw = 1'b1; end
      S_WAIT:  begin d_mem = 1'b1; d_rw = !is_store; d_mdr = !is_store; end
      S_LOUT:  begin d_mout = 1'b1; d_rw = 1'b1; d_rxi = onehot(q_p1); end
      S_DONE:  d_done = 1'b1;
      // A bad register index skips the faulting instruction; a timeout does not.
      S_ERR:   begin d_err = 1'b1; d_pc = (err_code_q == 2'b01); end
      default: ;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      bus.busy       <= 1'b0;
      bus.done       <= 1'b0;
      bus.err        <= 1'b0;
      bus.memEN      <= 1'b0;
      bus.RW         <= 1'b0;
      bus.marIn      <= 1'b0;
      bus.mdrWriteEN <= 1'b0;
      bus.mdrReadEN  <= 1'b0;
      bus.mdrOut     <= 1'b0;
      bus.pcInc      <= 1'b0;
      bus.rxOut      <= '0;
      bus.rxIn       <= '0;
    end else begin
      bus.busy       <= d_busy;
      bus.done       <= d_done;
      bus.err        <= d_err;
      bus.memEN      <= d_mem;
      bus.RW         <= d_rw;
      bus.marIn      <= d_mar;
      bus.mdrWriteEN <= d_mdw;
      bus.mdrReadEN  <= d_mdr;
      bus.mdrOut     <= d_mout;
      bus.pcInc      <= d_pc;
      bus.rxOut      <= d_rxo;
      bus.rxIn       <= d_rxi;
    end
  end
endmodule

// File: tb/tb_mem_access_fsm.sv
// tb/tb_mem_access_fsm.sv - directed bench for mem_access_fsm (6-reg/16-bit and 8-reg/20-bit builds)
module tb_mem_access_fsm;
  logic clk = 1'b0;
  logic rst = 1'b1;
  int   errors = 0;
  int   checks = 0;

  always #5 clk = ~clk;

  mem_access_fsm_if #(.DATA_W(16), .NREG(6)) b1 ();
  mem_access_fsm_if #(.DATA_W(20), .NREG(8)) b2 ();

  mem_access_fsm #(.DATA_W(16), .NREG(6)) dut1 (.clk(clk), .rst(rst), .bus(b1));
  mem_access_fsm #(.DATA_W(20), .NREG(8)) dut2 (.clk(clk), .rst(rst), .bus(b2));

  localparam logic [9:0] F_BUSY = 10'h200, F_DONE = 10'h100, F_ERR = 10'h080, F_MEM = 10'h040,
                         F_RW   = 10'h020, F_MAR  = 10'h010, F_MDW = 10'h008, F_MDR = 10'h004,
                         F_MOUT = 10'h002, F_PC   = 10'h001;

  function automatic logic [31:0] snap1();
    return {10'd0, b1.busy, b1.done, b1.err, b1.memEN, b1.RW, b1.marIn, b1.mdrWriteEN,
            b1.mdrReadEN, b1.mdrOut, b1.pcInc, b1.rxOut, b1.rxIn};
  endfunction

  function automatic logic [31:0] snap2();
    return {6'd0, b2.busy, b2.done, b2.err, b2.memEN, b2.RW, b2.marIn, b2.mdrWriteEN,
            b2.mdrReadEN, b2.mdrOut, b2.pcInc, b2.rxOut, b2.rxIn};
  endfunction

  function automatic logic [31:0] e1(input logic [9:0] f, input logic [5:0] rxo, input logic [5:0] rxi);
    return {10'd0, f, rxo, rxi};
  endfunction

  function automatic logic [31:0] e2(input logic [9:0] f, input logic [7:0] rxo, input logic [7:0] rxi);
    return {6'd0, f, rxo, rxi};
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      errors++;
      $error("FAIL %s: observed=%08h expected=%08h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    b1.IF_active = 1'b0; b1.instruction = '0; b1.MFC = 1'b0;
    b2.IF_active = 1'b0; b2.instruction = '0; b2.MFC = 1'b0;
    tick(); tick();
    chk("reset_outputs", snap1(), 32'd0);
    chk("reset_err_code", 32'(b1.err_code), 32'd0);
    rst = 1'b0;
    tick();
    chk("idle_outputs", snap1(), 32'd0);

    // Store 0x4085: p1=2 -> 001000, p2=5 -> 000001; MFC on third WAIT cycle
    b1.instruction = 16'h4085;
    tick(); b1.instruction = '0;
    chk("st_start", snap1(), 32'd0);
    tick(); chk("st_addr",  snap1(), e1(F_BUSY | F_PC,  6'b000001, 6'b0));
    tick(); chk("st_mar",   snap1(), e1(F_BUSY | F_MAR, 6'b000001, 6'b0));
    tick(); chk("st_sdata", snap1(), e1(F_BUSY,         6'b001000, 6'b0));
    tick(); chk("st_smdr",  snap1(), e1(F_BUSY | F_MDW, 6'b001000, 6'b0));
    tick(); chk("st_wait0", snap1(), e1(F_BUSY | F_MEM, 6'b0, 6'b0));
    tick(); chk("st_wait1", snap1(), e1(F_BUSY | F_MEM, 6'b0, 6'b0));
    b1.MFC = 1'b1;
    tick(); chk("st_wait2", snap1(), e1(F_BUSY | F_MEM, 6'b0, 6'b0));
    b1.MFC = 1'b0;
    tick(); chk("st_done", snap1(), e1(F_BUSY | F_DONE, 6'b0, 6'b0));
    tick(); chk("st_idle", snap1(), 32'd0);

    // Load 0x3043: p1=1 -> 010000, p2=3 -> 000100; MFC on first WAIT cycle
    b1.instruction = 16'h3043;
    tick(); b1.instruction = '0;
    tick(); chk("ld_addr", snap1(), e1(F_BUSY | F_PC,  6'b000100, 6'b0));
    tick(); chk("ld_mar",  snap1(), e1(F_BUSY | F_MAR, 6'b000100, 6'b0));
    b1.MFC = 1'b1;
    tick(); chk("ld_wait", snap1(), e1(F_BUSY | F_MEM | F_RW | F_MDR, 6'b0, 6'b0));
    b1.MFC = 1'b0;
    tick(); chk("ld_lout", snap1(), e1(F_BUSY | F_MOUT | F_RW, 6'b0, 6'b010000));
    tick(); chk("ld_done", snap1(), e1(F_BUSY | F_DONE, 6'b0, 6'b0));
    tick(); chk("ld_idle", snap1(), 32'd0);

    // Timeout: load with MFC held low for all 15 WAIT cycles
    b1.instruction = 16'h3043;
    tick(); b1.instruction = '0;
    tick(); tick();
    for (int i = 0; i < 15; i++) begin
      tick(); chk("to_wait", snap1(), e1(F_BUSY | F_MEM | F_RW | F_MDR, 6'b0, 6'b0));
    end
    chk("to_code_set", 32'(b1.err_code), 32'd2);
    tick(); chk("to_err", snap1(), e1(F_BUSY | F_ERR, 6'b0, 6'b0));
    chk("to_code_err", 32'(b1.err_code), 32'd2);
    tick(); chk("to_idle", snap1(), 32'd0);
    chk("to_code_held", 32'(b1.err_code), 32'd2);

    // MFC arrives on the 15th WAIT cycle: completes normally
    b1.instruction = 16'h3043;
    tick(); b1.instruction = '0;
    chk("to15_code_clr", 32'(b1.err_code), 32'd0);
    tick(); tick();
    for (int i = 0; i < 14; i++) begin
      tick(); chk("to15_wait", snap1(), e1(F_BUSY | F_MEM | F_RW | F_MDR, 6'b0, 6'b0));
    end
    b1.MFC = 1'b1;
    tick(); chk("to15_wait_last", snap1(), e1(F_BUSY | F_MEM | F_RW | F_MDR, 6'b0, 6'b0));
    b1.MFC = 1'b0;
    tick(); chk("to15_lout", snap1(), e1(F_BUSY | F_MOUT | F_RW, 6'b0, 6'b010000));
    tick(); chk("to15_done", snap1(), e1(F_BUSY | F_DONE, 6'b0, 6'b0));
    chk("to15_code", 32'(b1.err_code), 32'd0);
    tick(); chk("to15_idle", snap1(), 32'd0);

    // Bad register: p2=7 with NREG=6
    b1.instruction = 16'h4007;
    tick(); b1.instruction = '0;
    chk("bad_code", 32'(b1.err_code), 32'd1);
    tick(); chk("bad_err", snap1(), e1(F_BUSY | F_ERR | F_PC, 6'b0, 6'b0));
    tick(); chk("bad_idle", snap1(), 32'd0);
    chk("bad_code_held", 32'(b1.err_code), 32'd1);

    // Abort with IF_active while in SMDR
    b1.instruction = 16'h4085;
    tick(); b1.instruction = '0;
    chk("ab_code_clr", 32'(b1.err_code), 32'd0);
    tick(); tick(); tick();
    b1.IF_active = 1'b1;
    tick(); b1.IF_active = 1'b0;
    chk("ab_smdr", snap1(), e1(F_BUSY | F_MDW, 6'b001000, 6'b0));
    for (int i = 0; i < 4; i++) begin
      tick(); chk("ab_idle", snap1(), 32'd0);
    end

    // Reset during WAIT after a timeout left err_code = 10
    b1.instruction = 16'h3043;
    tick(); b1.instruction = '0;
    for (int i = 0; i < 17; i++) tick();
    chk("rs_pre_code", 32'(b1.err_code), 32'd2);
    tick(); tick();
    b1.instruction = 16'h3043;
    tick(); b1.instruction = '0;
    tick(); tick(); tick(); tick();
    chk("rs_in_wait", snap1(), e1(F_BUSY | F_MEM | F_RW | F_MDR, 6'b0, 6'b0));
    rst = 1'b1;
    #1;
    chk("rs_async", snap1(), 32'd0);
    chk("rs_code", 32'(b1.err_code), 32'd0);
    tick(); rst = 1'b0;
    for (int i = 0; i < 3; i++) begin
      tick(); chk("rs_idle", snap1(), 32'd0);
    end
    chk("rs_code_after", 32'(b1.err_code), 32'd0);

    // 8-register, 20-bit build: load p1=7 -> 00000001, p2=0 -> 10000000
    b2.instruction = 20'h30700;
    tick(); b2.instruction = '0;
    tick(); chk("p8_addr", snap2(), e2(F_BUSY | F_PC,  8'h80, 8'h00));
    tick(); chk("p8_mar",  snap2(), e2(F_BUSY | F_MAR, 8'h80, 8'h00));
    b2.MFC = 1'b1;
    tick(); chk("p8_wait", snap2(), e2(F_BUSY | F_MEM | F_RW | F_MDR, 8'h00, 8'h00));
    b2.MFC = 1'b0;
    tick(); chk("p8_lout", snap2(), e2(F_BUSY | F_MOUT | F_RW, 8'h00, 8'h01));
    tick(); chk("p8_done", snap2(), e2(F_BUSY | F_DONE, 8'h00, 8'h00));
    tick(); chk("p8_idle", snap2(), 32'd0);
    chk("p8_dut1_quiet", snap1(), 32'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
